// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at acceptance, then held pending until the latency counter expires.
module mul_div_unit #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic             cancel,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall_req
);

   localparam int unsigned DW = 2 * WIDTH;

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMthi  = 4'd5;
   localparam logic [3:0] OpMtlo  = 4'd6;
   localparam logic [3:0] OpMadd  = 4'd7;
   localparam logic [3:0] OpMaddu = 4'd8;
   localparam logic [3:0] OpMsub  = 4'd9;
   localparam logic [3:0] OpMsubu = 4'd10;

   localparam logic [4:0] MultLat = 5'(MULT_CYCLES);
   localparam logic [4:0] DivLat  = 5'(DIV_CYCLES);

   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

   logic is_mul, is_div, is_sgn, is_add, is_sub;

   always_comb begin
      is_mul = 1'b0;
      is_div = 1'b0;
      is_sgn = 1'b0;
      is_add = 1'b0;
      is_sub = 1'b0;
      case (op)
         OpMult:  begin is_mul = 1'b1; is_sgn = 1'b1; end
         OpMultu: is_mul = 1'b1;
         OpDiv:   begin is_div = 1'b1; is_sgn = 1'b1; end
         OpDivu:  is_div = 1'b1;
         OpMadd:  begin is_mul = 1'b1; is_sgn = 1'b1; is_add = 1'b1; end
         OpMaddu: begin is_mul = 1'b1; is_add = 1'b1; end
         OpMsub:  begin is_mul = 1'b1; is_sgn = 1'b1; is_sub = 1'b1; end
         OpMsubu: begin is_mul = 1'b1; is_sub = 1'b1; end
         default: ;
      endcase
   end

   // Multiply path: sign/zero-extend to 2*WIDTH so the truncated product is exact.
   logic [DW-1:0] opa_ext, opb_ext, prod, hilo, mul_res;

   assign opa_ext = is_sgn ? {{WIDTH{d1[WIDTH-1]}}, d1} : {{WIDTH{1'b0}}, d1};
   assign opb_ext = is_sgn ? {{WIDTH{d2[WIDTH-1]}}, d2} : {{WIDTH{1'b0}}, d2};
   assign prod    = opa_ext * opb_ext;
   assign hilo    = {hi_q, lo_q};
   assign mul_res = is_add ? hilo + prod : (is_sub ? hilo - prod : prod);

   // Divide path on magnitudes; most-negative / -1 wraps back to d1 with zero remainder.
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

   assign a_neg  = is_sgn & d1[WIDTH-1];
   assign b_neg  = is_sgn & d2[WIDTH-1];
   assign a_mag  = a_neg ? -d1 : d1;
   assign b_mag  = b_neg ? -d2 : d2;
   assign b_safe = (d2 == '0) ? WIDTH'(1) : b_mag;
   assign q_mag  = a_mag / b_safe;
   assign r_mag  = a_mag % b_safe;
   assign quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign rem    = a_neg ? -r_mag : r_mag;

   assign busy      = (cnt_q != 5'd0);
   assign stall_req = busy | (start & (is_mul | is_div));
   assign hi        = hi_q;
   assign lo        = lo_q;

   always_comb begin
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      if (cancel) begin
         cnt_d     = 5'd0;
         pend_hi_d = '0;
         pend_lo_d = '0;
      end else if (busy) begin
         cnt_d = cnt_q - 5'd1;
         if (cnt_q == 5'd1) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end else if (start) begin
         if (is_mul) begin
            cnt_d                  = MultLat;
            {pend_hi_d, pend_lo_d} = mul_res;
         end else if (is_div) begin
            cnt_d = DivLat;
            // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
            {pend_hi_d, pend_lo_d} = (d2 == '0) ? hilo : {rem, quo};
         end else if (op == OpMthi) begin
            hi_d = d1;
         end else if (op == OpMtlo) begin
            lo_d = d1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= 5'd0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed checks at WIDTH=32 plus randomized runs on two
// configurations, compared cycle by cycle against an arithmetic reference model.
module tb_mul_div_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n    [2];
   logic        start_a  [2];
   logic [3:0]  op_a     [2];
   logic [31:0] d1_a     [2];
   logic [31:0] d2_a     [2];
   logic        cancel_a [2];

   logic [31:0] hi0, lo0;
   logic [15:0] hi1, lo1;
   logic        busy0, busy1, stall0, stall1;

   mul_div_unit u_dut0 (
      .clk       (clk),
      .reset_n   (rst_n[0]),
      .start     (start_a[0]),
      .op        (op_a[0]),
      .d1        (d1_a[0]),
      .d2        (d2_a[0]),
      .cancel    (cancel_a[0]),
      .hi        (hi0),
      .lo        (lo0),
      .busy      (busy0),
      .stall_req (stall0)
   );

   mul_div_unit #(
      .WIDTH       (16),
      .MULT_CYCLES (1),
      .DIV_CYCLES  (31)
   ) u_dut1 (
      .clk       (clk),
      .reset_n   (rst_n[1]),
      .start     (start_a[1]),
      .op        (op_a[1]),
      .d1        (d1_a[1][15:0]),
      .d2        (d2_a[1][15:0]),
      .cancel    (cancel_a[1]),
      .hi        (hi1),
      .lo        (lo1),
      .busy      (busy1),
      .stall_req (stall1)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   int unsigned w_of  [2] = '{32, 16};
   int unsigned mc_of [2] = '{5, 1};
   int unsigned dc_of [2] = '{10, 31};

   // Reference state: committed HI/LO, result waiting to land, cycles left in flight.
   longint unsigned m_hi [2], m_lo [2], m_pend [2];
   int              m_rem [2];

   function automatic longint unsigned mask(input longint unsigned v, input int unsigned n);
      return (n >= 64) ? v : (v & ((64'd1 << n) - 64'd1));
   endfunction

   function automatic longint sx(input longint unsigned v, input int unsigned w);
      return $signed(v << (64 - w)) >>> (64 - w);
   endfunction

   function automatic bit is_md(input logic [3:0] o);
      return o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};
   endfunction

   function automatic longint unsigned ref_op(input int unsigned w, input logic [3:0] o,
                                              input longint unsigned a, input longint unsigned b,
                                              input longint unsigned hl);
      longint sa = sx(a, w);
      longint sb = sx(b, w);
      longint q, r;
      case (o)
         4'd1:  return mask(sa * sb, 2 * w);
         4'd2:  return mask(a * b, 2 * w);
         4'd7:  return mask(hl + sa * sb, 2 * w);
         4'd8:  return mask(hl + a * b, 2 * w);
         4'd9:  return mask(hl - sa * sb, 2 * w);
         4'd10: return mask(hl - a * b, 2 * w);
         4'd3: begin
            if (b == 0) return hl;
            q = sa / sb;
            r = sa % sb;
            return (mask(r, w) << w) | mask(q, w);
         end
         4'd4: begin
            if (b == 0) return hl;
            return ((a % b) << w) | (a / b);
         end
         default: return hl;
      endcase
   endfunction

   function automatic longint unsigned hi_of(input int i);
      return (i == 1) ? 64'(hi1) : 64'(hi0);
   endfunction
   function automatic longint unsigned lo_of(input int i);
      return (i == 1) ? 64'(lo1) : 64'(lo0);
   endfunction
   function automatic longint unsigned busy_of(input int i);
      return (i == 1) ? 64'(busy1) : 64'(busy0);
   endfunction
   function automatic longint unsigned stall_of(input int i);
      return (i == 1) ? 64'(stall1) : 64'(stall0);
   endfunction

   task automatic model_reset(input int i);
      m_hi[i]   = 0;
      m_lo[i]   = 0;
      m_pend[i] = 0;
      m_rem[i]  = 0;
   endtask

   // One clock: drive just after a rising edge, check at the falling edge, advance the model.
   task automatic cyc(input int i, input bit s, input logic [3:0] o,
                      input longint unsigned a_in, input longint unsigned b_in, input bit c);
      int unsigned     w = w_of[i];
      longint unsigned a = mask(a_in, w);
      longint unsigned b = mask(b_in, w);
      longint unsigned hl;
      start_a[i]  = s;
      op_a[i]     = o;
      d1_a[i]     = 32'(a);
      d2_a[i]     = 32'(b);
      cancel_a[i] = c;
      @(negedge clk);
      check($sformatf("i%0d_busy", i), busy_of(i), 64'(m_rem[i] > 0));
      check($sformatf("i%0d_stall_req", i), stall_of(i), 64'((m_rem[i] > 0) || (s && is_md(o))));
      check($sformatf("i%0d_hi", i), hi_of(i), m_hi[i]);
      check($sformatf("i%0d_lo", i), lo_of(i), m_lo[i]);
      @(posedge clk);
      hl = (m_hi[i] << w) | m_lo[i];
      if (c) begin
         m_rem[i] = 0;
      end else if (m_rem[i] > 0) begin
         m_rem[i]--;
         if (m_rem[i] == 0) begin
            m_hi[i] = mask(m_pend[i] >> w, w);
            m_lo[i] = mask(m_pend[i], w);
         end
      end else if (s) begin
         if (is_md(o)) begin
            m_pend[i] = ref_op(w, o, a, b, hl);
            m_rem[i]  = (o == 4'd3 || o == 4'd4) ? int'(dc_of[i]) : int'(mc_of[i]);
         end else if (o == 4'd5) begin
            m_hi[i] = a;
         end else if (o == 4'd6) begin
            m_lo[i] = a;
         end
      end
      #1;
   endtask

   // Issue one op, then idle until busy drops; nb counts observed busy cycles.
   task automatic run_op(input int i, input logic [3:0] o, input longint unsigned a,
                         input longint unsigned b, output int nb);
      cyc(i, 1'b1, o, a, b, 1'b0);
      nb = 0;
      for (int k = 0; k < 40 && busy_of(i) != 0; k++) begin
         nb++;
         cyc(i, 1'b0, 4'd0, 0, 0, 1'b0);
      end
   endtask

   function automatic longint unsigned rnd_val(input int unsigned w);
      case ($urandom_range(0, 7))
         0:       return 0;
         1:       return 1;
         2:       return mask(64'hFFFF_FFFF_FFFF_FFFF, w);
         3:       return 64'd1 << (w - 1);
         4:       return 64'($urandom_range(0, 9));
         default: return mask({$urandom, $urandom}, w);
      endcase
   endfunction

   task automatic run_random(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         cyc(i, $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)),
             rnd_val(w_of[i]), rnd_val(w_of[i]), $urandom_range(0, 24) == 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int nb;
      rst_n    = '{1'b0, 1'b0};
      start_a  = '{1'b1, 1'b0};
      op_a     = '{4'd1, 4'd0};
      d1_a     = '{32'd0, 32'd0};
      d2_a     = '{32'd0, 32'd0};
      cancel_a = '{1'b0, 1'b0};
      model_reset(0);
      model_reset(1);

      // In reset: idle, zeroed, stall_req follows start/op alone.
      #2;
      check("rst_hi", 64'(hi0), 0);
      check("rst_lo", 64'(lo0), 0);
      check("rst_busy", 64'(busy0), 0);
      check("rst_stall_mult", 64'(stall0), 1);
      op_a[0] = 4'd5;
      #1;
      check("rst_stall_mthi", 64'(stall0), 0);
      start_a[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = '{1'b1, 1'b1};

      // mult -2 * 3
      run_op(0, 4'd1, 64'hFFFF_FFFE, 3, nb);
      check("mult_busy_len", 64'(nb), 5);
      check("mult_hi", 64'(hi0), 64'hFFFF_FFFF);
      check("mult_lo", 64'(lo0), 64'hFFFF_FFFA);

      // div -7 / 2, then divu by zero
      run_op(0, 4'd3, 64'hFFFF_FFF9, 2, nb);
      check("div_busy_len", 64'(nb), 10);
      check("div_lo", 64'(lo0), 64'hFFFF_FFFD);
      check("div_hi", 64'(hi0), 64'hFFFF_FFFF);
      run_op(0, 4'd4, 7, 0, nb);
      check("divz_busy_len", 64'(nb), 10);
      check("divz_lo", 64'(lo0), 64'hFFFF_FFFD);
      check("divz_hi", 64'(hi0), 64'hFFFF_FFFF);

      // mthi/mtlo then maddu
      cyc(0, 1'b1, 4'd5, 1, 0, 1'b0);
      cyc(0, 1'b1, 4'd6, 2, 0, 1'b0);
      check("mthi_hi", 64'(hi0), 1);
      run_op(0, 4'd8, 64'hFFFF_FFFF, 2, nb);
      check("maddu_hi", 64'(hi0), 3);
      check("maddu_lo", 64'(lo0), 0);

      // Cancel on busy cycle 3 with a start held throughout
      cyc(0, 1'b1, 4'd1, 5, 7, 1'b0);
      cyc(0, 1'b1, 4'd2, 9, 9, 1'b0);
      cyc(0, 1'b1, 4'd2, 9, 9, 1'b0);
      cyc(0, 1'b1, 4'd2, 9, 9, 1'b1);
      check("cancel_busy", 64'(busy0), 0);
      repeat (7) cyc(0, 1'b0, 4'd0, 0, 0, 1'b0);
      check("cancel_hi", 64'(hi0), 3);
      check("cancel_lo", 64'(lo0), 0);

      // Cancel coinciding with the final busy cycle suppresses the commit
      cyc(0, 1'b1, 4'd1, 5, 7, 1'b0);
      repeat (4) cyc(0, 1'b0, 4'd0, 0, 0, 1'b0);
      cyc(0, 1'b0, 4'd0, 0, 0, 1'b1);
      repeat (2) cyc(0, 1'b0, 4'd0, 0, 0, 1'b0);
      check("cancel_last_lo", 64'(lo0), 0);
      check("cancel_last_hi", 64'(hi0), 3);

      // Invalid op code leaves everything alone
      cyc(0, 1'b1, 4'd15, 64'h1234, 64'h5678, 1'b0);
      check("nop_hi", 64'(hi0), 3);

      // Signed overflow
      run_op(0, 4'd3, 64'h8000_0000, 64'hFFFF_FFFF, nb);
      check("ovf_lo", 64'(lo0), 64'h8000_0000);
      check("ovf_hi", 64'(hi0), 0);

      // Reset pulsed mid-divide
      cyc(0, 1'b1, 4'd3, 100, 7, 1'b0);
      repeat (2) cyc(0, 1'b0, 4'd0, 0, 0, 1'b0);
      cyc(0, 1'b1, 4'd6, 64'hDEAD, 0, 1'b0);
      start_a[0] = 1'b0;
      rst_n[0]   = 1'b0;
      #1;
      check("rstmid_hi", 64'(hi0), 0);
      check("rstmid_lo", 64'(lo0), 0);
      check("rstmid_busy", 64'(busy0), 0);
      #1;
      rst_n[0] = 1'b1;
      model_reset(0);
      cyc(0, 1'b1, 4'd6, 64'h55, 0, 1'b0);
      check("post_rst_mtlo", 64'(lo0), 64'h55);

      run_random(0, 1500);
      cyc(0, 1'b0, 4'd0, 0, 0, 1'b0);
      run_random(1, 3000);
      cyc(1, 1'b0, 4'd0, 0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width; legal values 8..64, even.
REQ-002 Parameter MULT_CYCLES, default 5: busy cycles per multiply-class op; legal values 1..31.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles per divide-class op; legal values 1..31.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset; one clock domain only.
REQ-006 start  input  1  qualifies op for one cycle.
REQ-007 op  input  4  operation code: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; other codes are no-op.
REQ-008 d1  input  WIDTH  operand A (rs).
REQ-009 d2  input  WIDTH  operand B (rt).
REQ-010 cancel  input  1  aborts any in-flight op (exception flush).
REQ-011 hi  output  WIDTH  architectural HI register.
REQ-012 lo  output  WIDTH  architectural LO register.
REQ-013 busy  output  1  registered; high while an op is in flight.
REQ-014 stall_req  output  1  combinational: busy OR (start AND op in {1,2,3,4,7,8,9,10}).

Function
REQ-015 Class M = ops 1,2,7,8,9,10 (MULT_CYCLES); class D = ops 3,4 (DIV_CYCLES); class T = ops 5,6.
REQ-016 Accept: on an edge with start=1, busy=0, cancel=0 and class M/D op, load the counter with the class latency N and latch the full result into pending_hi/pending_lo.
REQ-017 busy SHALL equal (counter != 0); it decrements by 1 each edge while nonzero.
REQ-018 On the edge where the counter goes 1->0, pending_hi/pending_lo SHALL be copied to hi/lo; after acceptance at edge E0, new hi/lo are visible after edge E0+N, and busy is high for exactly N cycles.
REQ-019 mult/multu: {hi,lo} = signed/unsigned d1*d2, full 2*WIDTH product.
REQ-020 madd/maddu: {hi,lo} = {hi,lo} + product; msub/msubu: {hi,lo} = {hi,lo} - product; both modulo 2^(2*WIDTH). The {hi,lo} operand is the value at the acceptance edge.
REQ-021 div: lo = signed quotient, truncated toward zero; hi = remainder, with the sign of d1. divu: the unsigned equivalent.
REQ-022 Signed overflow (d1 = most-negative, d2 = -1): lo = d1, hi = 0.
REQ-023 Divide by zero (d2 = 0): the op still occupies DIV_CYCLES, and hi/lo are left unchanged at completion.
REQ-024 mthi/mtlo: with start=1, busy=0, cancel=0, hi (or lo) = d1 at that edge; the op completes in zero busy cycles.
REQ-025 start while busy=1 SHALL be ignored, with no state change; the issuing stage holds on stall_req.
REQ-026 Invalid op codes with start=1 SHALL change no state, and stall_req SHALL stay 0 for them.
REQ-027 cancel=1 SHALL clear the counter and discard pending results at that edge; hi/lo keep their pre-op values; any start in the same cycle is ignored.
REQ-028 When cancel=1 and the counter is 1 at the same edge, cancel wins and no commit occurs.
REQ-029 A new op may be accepted on the edge immediately after busy falls; back-to-back ops need no idle cycle.
REQ-030 hi/lo outputs SHALL reflect only committed state, never pending values.

Reset
REQ-031 reset_n=0 asynchronously forces hi=0, lo=0, counter=0, busy=0, pending_hi=0, pending_lo=0.
REQ-032 An assertion of reset_n mid-operation abandons the op; after release the unit is idle and accepts on the first edge.
REQ-033 stall_req depends only on start/op while in reset, because busy=0.

Verification
REQ-034 WIDTH=32, MULT_CYCLES=5: mult d1=0xFFFFFFFE (-2), d2=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 div d1=-7, d2=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu d1=7, d2=0 -> hi/lo unchanged.
REQ-036 mthi 1, mtlo 2, then maddu d1=0xFFFFFFFF, d2=2 -> hi=0x00000003, lo=0x00000000.
REQ-037 mult accepted, cancel asserted on busy cycle 3 -> busy=0 next cycle; hi/lo equal pre-op values; a start held during busy was not accepted.
REQ-038 div d1=0x80000000, d2=0xFFFFFFFF -> lo=0x80000000, hi=0; reset_n pulsed during a div -> hi=lo=0, busy=0 immediately.
REQ-039 Parameter sweep WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=31 -> random ops checked against a reference model; checks cover busy duration and stall_req.
